// File: rtl/ir_cam_pkg.sv
// Shared constants, FSM encoding and read-map helper for the IR camera I2C responder.
package ir_cam_pkg;

  localparam logic [6:0]  CAM_ADDR        = 7'h58;
  localparam logic [7:0]  REG_CTRL        = 8'h30;
  localparam logic [7:0]  REG_SENS        = 8'h33;
  localparam logic [7:0]  REG_REPORT      = 8'h36;
  localparam int unsigned REPORT_LEN      = 16;
  localparam logic [7:0]  REG_REPORT_LAST = REG_REPORT + 8'(REPORT_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck
  } i2c_state_e;

  // Byte served for a read pointer; rep1..rep3 are the snapshotted report bytes 1..3.
  function automatic logic [7:0] read_map(input logic [7:0] ptr,
                                          input logic [7:0] ctrl,
                                          input logic [7:0] sens,
                                          input logic [7:0] rep1,
                                          input logic [7:0] rep2,
                                          input logic [7:0] rep3);
    logic [7:0] idx;
    logic [7:0] res;
    idx = ptr - REG_REPORT;
    res = 8'h00;
    if (ptr == REG_CTRL) begin
      res = ctrl;
    end else if (ptr == REG_SENS) begin
      res = sens;
    end else if (ptr >= REG_REPORT && ptr <= REG_REPORT_LAST) begin
      case (idx)
        8'd0:    res = 8'h00;
        8'd1:    res = rep1;
        8'd2:    res = rep2;
        8'd3:    res = rep3;
        default: res = 8'hFF;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges and START/STOP conditions.
module i2c_bus_sync #(
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_DEPTH-1:0] scl_sync_q;
  logic [SYNC_DEPTH-1:0] sda_sync_q;
  logic                  scl_prev_q;
  logic                  sda_prev_q;
  logic                  scl_s;
  logic                  sda_s;

  // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_DEPTH-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_DEPTH-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s       = scl_sync_q[SYNC_DEPTH-1];
  assign sda_s       = sda_sync_q[SYNC_DEPTH-1];
  assign scl_rise_o  = scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s & scl_prev_q;
  assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign sda_s_o     = sda_s;

endmodule

// File: rtl/ir_cam_i2c_responder.sv
// I2C target emulating the IR blob camera: register writes via pointer, 16-byte position reads.
module ir_cam_i2c_responder
  import ir_cam_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = CAM_ADDR,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda,
  input  logic [9:0] blob_x,
  input  logic [9:0] blob_y,
  input  logic [3:0] blob_size,
  input  logic       blob_valid,
  output logic [7:0] cfg_ctrl,
  output logic [7:0] cfg_sens,
  output logic       cfg_wr,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_DEPTH(SYNC_DEPTH)
  ) u_sync (
    .clk_i      (clk),
    .reset_i    (reset),
    .scl_i      (i2c_scl),
    .sda_i      (i2c_sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_s_o    (sda_s)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] ptr_q, ptr_d;
  logic       first_q, first_d;
  logic       rw_q, rw_d;
  logic       sda_q, sda_d;
  logic       busy_q, busy_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] sens_q, sens_d;
  logic       wr_q, wr_d;
  logic [7:0] rep1_q, rep1_d;
  logic [7:0] rep2_q, rep2_d;
  logic [7:0] rep3_q, rep3_d;

  logic [7:0] shifted;
  logic [7:0] rd_data;

  assign shifted = {sr_q[6:0], sda_s};
  assign rd_data = read_map(ptr_q, ctrl_q, sens_q, rep1_q, rep2_q, rep3_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      sr_q    <= 8'h00;
      ptr_q   <= 8'h00;
      first_q <= 1'b0;
      rw_q    <= 1'b0;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      ctrl_q  <= 8'h00;
      sens_q  <= 8'h00;
      wr_q    <= 1'b0;
      rep1_q  <= 8'hFF;
      rep2_q  <= 8'hFF;
      rep3_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      rw_q    <= rw_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      ctrl_q  <= ctrl_d;
      sens_q  <= sens_d;
      wr_q    <= wr_d;
      rep1_q  <= rep1_d;
      rep2_q  <= rep2_d;
      rep3_q  <= rep3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    rw_d    = rw_q;
    sda_d   = sda_q;
    busy_d  = busy_q;
    ctrl_d  = ctrl_q;
    sens_d  = sens_q;
    wr_d    = 1'b0;
    rep1_d  = rep1_q;
    rep2_d  = rep2_q;
    rep3_d  = rep3_q;

    // Bus conditions override whatever data phase is in progress.
    if (stop_det) begin
      state_d = StIdle;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        StIdle: ;

        StAddr: begin
          if (scl_rise) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (shifted[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
                rw_d    = shifted[0];
                first_d = 1'b1;
              end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // cnt 0: waiting for the fall that opens the ACK slot; cnt 1: ACK slot in progress.
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_d = 1'b0;
              cnt_d = 4'd1;
              if (state_q == StAddrAck && rw_q) begin
                rep1_d = blob_valid ? blob_x[7:0] : 8'hFF;
                rep2_d = blob_valid ? blob_y[7:0] : 8'hFF;
                rep3_d = blob_valid ? {blob_y[9:8], blob_x[9:8], blob_size} : 8'hFF;
              end
            end else begin
              cnt_d = 4'd0;
              if (state_q == StAddrAck && rw_q) begin
                sr_d    = rd_data;
                sda_d   = rd_data[7];
                state_d = StRdByte;
              end else begin
                sda_d   = 1'b1;
                state_d = StWrByte;
              end
            end
          end
        end

        StWrByte: begin
          if (scl_rise) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              state_d = StWrAck;
              if (first_q) begin
                ptr_d   = shifted;
                first_d = 1'b0;
              end else begin
                wr_d  = 1'b1;
                ptr_d = ptr_q + 8'd1;
                if (ptr_q == REG_CTRL) begin
                  ctrl_d = shifted;
                end else if (ptr_q == REG_SENS) begin
                  sens_d = shifted;
                end
              end
            end
          end
        end

        StRdByte: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
              ptr_d   = ptr_q + 8'd1;
              state_d = StRdAck;
            end else begin
              sr_d  = {sr_q[6:0], 1'b0};
              sda_d = sr_q[6];
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d   = 4'd0;
            sr_d    = rd_data;
            sda_d   = rd_data[7];
            state_d = StRdByte;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  assign i2c_sda  = sda_q;
  assign cfg_ctrl = ctrl_q;
  assign cfg_sens = sens_q;
  assign cfg_wr   = wr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ir_cam_i2c_responder.sv
// Directed bench: bit-banged I2C initiator against the camera responder, open-drain SDA model.
module tb_ir_cam_i2c_responder;

  localparam int Q = 100;  // quarter SCL period; clk period is 10

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [9:0] blob_x = 10'h2A5;
  logic [9:0] blob_y = 10'h1C3;
  logic [3:0] blob_size = 4'd5;
  logic       blob_valid = 1'b1;
  logic       i2c_sda;
  logic [7:0] cfg_ctrl;
  logic [7:0] cfg_sens;
  logic       cfg_wr;
  logic       busy;
  logic       sda_line;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int          wr_count = 0;
  logic [7:0]  exp_bytes [16];

  assign sda_line = sda_m & i2c_sda;

  always #5 clk = ~clk;

  always @(posedge clk) if (cfg_wr === 1'b1) wr_count <= wr_count + 1;

  ir_cam_i2c_responder dut (
    .clk       (clk),
    .reset     (reset),
    .i2c_scl   (scl),
    .i2c_sda_in(sda_line),
    .i2c_sda   (i2c_sda),
    .blob_x    (blob_x),
    .blob_y    (blob_y),
    .blob_size (blob_size),
    .blob_valid(blob_valid),
    .cfg_ctrl  (cfg_ctrl),
    .cfg_sens  (cfg_sens),
    .cfg_wr    (cfg_wr),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;
    #Q scl = 1'b1;
    #Q s = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(mack, s);
  endtask

  // Set the pointer, repeated-start into a read of n bytes (NACK on the last), then STOP.
  task automatic read_seq(input logic [7:0] ptr, input int n, input string tag);
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    wr_byte(8'hB0, a0);
    wr_byte(ptr, a1);
    i2c_start();
    wr_byte(8'hB1, a2);
    check({tag, " acks"}, {29'd0, a0, a1, a2}, 32'd0);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      check($sformatf("%s byte%0d", tag, i), {24'd0, d}, {24'd0, exp_bytes[i]});
    end
    check({tag, " sda released"}, {31'd0, i2c_sda}, 32'd1);
    check({tag, " busy after nack"}, {31'd0, busy}, 32'd0);
    i2c_stop();
  endtask

  initial begin
    logic a0, a1, a2;
    logic [7:0] d;
    int w0;

    repeat (5) @(posedge clk);
    #1;
    check("reset sda", {31'd0, i2c_sda}, 32'd1);
    check("reset cfg_ctrl", {24'd0, cfg_ctrl}, 32'd0);
    check("reset cfg_sens", {24'd0, cfg_sens}, 32'd0);
    check("reset cfg_wr", {31'd0, cfg_wr}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset = 1'b0;
    #Q;

    // 1: single register write
    w0 = wr_count;
    i2c_start();
    wr_byte(8'hB0, a0);
    check("t1 busy after match", {31'd0, busy}, 32'd1);
    wr_byte(8'h30, a1);
    wr_byte(8'h01, a2);
    check("t1 acks", {29'd0, a0, a1, a2}, 32'd0);
    check("t1 cfg_ctrl", {24'd0, cfg_ctrl}, 32'h01);
    check("t1 cfg_wr pulses", wr_count - w0, 32'd1);
    i2c_stop();
    #Q;
    check("t1 busy after stop", {31'd0, busy}, 32'd0);

    // 2: two writes in separate transactions
    w0 = wr_count;
    i2c_start();
    wr_byte(8'hB0, a0);
    wr_byte(8'h30, a1);
    wr_byte(8'h08, a2);
    i2c_stop();
    i2c_start();
    wr_byte(8'hB0, a0);
    wr_byte(8'h33, a1);
    wr_byte(8'h33, a2);
    i2c_stop();
    check("t2 cfg_ctrl", {24'd0, cfg_ctrl}, 32'h08);
    check("t2 cfg_sens", {24'd0, cfg_sens}, 32'h33);
    check("t2 cfg_wr pulses", wr_count - w0, 32'd2);

    // 3: full 16-byte report read
    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'hA5;
    exp_bytes[2] = 8'hC3;
    exp_bytes[3] = 8'h65;
    for (int i = 4; i < 16; i++) exp_bytes[i] = 8'hFF;
    read_seq(8'h36, 16, "t3 report");

    // pointer now 0x46, just past the report: unmapped
    i2c_start();
    wr_byte(8'hB1, a0);
    rd_byte(1'b1, d);
    check("t3 past report ack", {31'd0, a0}, 32'd0);
    check("t3 past report byte", {24'd0, d}, 32'h00);
    i2c_stop();

    // config registers and the holes between them
    exp_bytes[0] = 8'h08;
    exp_bytes[1] = 8'h00;
    exp_bytes[2] = 8'h00;
    exp_bytes[3] = 8'h33;
    read_seq(8'h30, 4, "cfg map");

    // 4: wrong address is ignored
    w0 = wr_count;
    i2c_start();
    wr_byte(8'h42, a0);
    check("t4 nack", {31'd0, a0}, 32'd1);
    check("t4 busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    check("t4 cfg_ctrl", {24'd0, cfg_ctrl}, 32'h08);
    check("t4 cfg_sens", {24'd0, cfg_sens}, 32'h33);
    check("t4 cfg_wr pulses", wr_count - w0, 32'd0);

    // 5: blob change mid-read stays invisible until the next read
    i2c_start();
    wr_byte(8'hB0, a0);
    wr_byte(8'h36, a1);
    i2c_start();
    wr_byte(8'hB1, a2);
    rd_byte(1'b0, d);
    check("t5 byte0", {24'd0, d}, 32'h00);
    blob_x = 10'h15A;
    rd_byte(1'b0, d);
    check("t5 byte1 held", {24'd0, d}, 32'hA5);
    rd_byte(1'b0, d);
    check("t5 byte2", {24'd0, d}, 32'hC3);
    rd_byte(1'b1, d);
    check("t5 byte3 held", {24'd0, d}, 32'h65);
    i2c_stop();
    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'h5A;
    exp_bytes[2] = 8'hC3;
    exp_bytes[3] = 8'h55;
    read_seq(8'h36, 4, "t5 new snapshot");

    // no blob: coordinate bytes read as 0xFF
    blob_valid = 1'b0;
    exp_bytes[0] = 8'hFF;
    exp_bytes[1] = 8'hFF;
    exp_bytes[2] = 8'hFF;
    read_seq(8'h37, 3, "no blob");
    blob_valid = 1'b1;

    // 6: reset while driving a 0 data bit
    i2c_start();
    wr_byte(8'hB0, a0);
    wr_byte(8'h36, a1);
    i2c_start();
    wr_byte(8'hB1, a2);
    check("t6 driving zero", {31'd0, i2c_sda}, 32'd0);
    #3 reset = 1'b1;
    #1;
    check("t6 sda on reset", {31'd0, i2c_sda}, 32'd1);
    check("t6 cfg_ctrl on reset", {24'd0, cfg_ctrl}, 32'h00);
    #50 reset = 1'b0;
    #Q;
    i2c_start();
    wr_byte(8'hB0, a0);
    wr_byte(8'h33, a1);
    wr_byte(8'h5A, a2);
    i2c_stop();
    check("t6 acks after reset", {29'd0, a0, a1, a2}, 32'd0);
    check("t6 cfg_sens", {24'd0, cfg_sens}, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
